// File: rtl/cfg_bitstream_loader_if.sv
// Byte stream from the host configuration port into the loader.
// The master drives data/valid; the loader (slave) returns ready.
interface cfg_bitstream_loader_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;

   modport master (
      output s_data,
      output s_valid,
      input  s_ready
   );

   modport slave (
      input  s_data,
      input  s_valid,
      output s_ready
   );
endinterface

// File: rtl/cfg_bitstream_loader.sv
// Configuration daisy-chain loader: clears the chain, then shifts host
// bytes MSB-first. Define CFG_CRC_EN for a trailing CRC-8 check byte.
module cfg_bitstream_loader #(
   parameter int TOTAL_BITS   = 16,
   parameter int CLEAR_CYCLES = 4,
   parameter int DONE_TIMEOUT = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   cfg_bitstream_loader_if.slave cfg_in,
   output logic                  cfg_clear,
   output logic                  prgm_b,
   output logic                  chain_en,
   output logic                  shift_en,
   output logic                  bit_out,
   input  logic                  chain_done_in,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           bits_sent
`ifdef CFG_CRC_EN
   ,
   output logic                  crc_ok
`endif
);

   localparam logic [16:0] TOTAL    = 17'(TOTAL_BITS);
   localparam logic [7:0]  CLR_LAST = 8'(CLEAR_CYCLES - 1);
   localparam logic [15:0] TMO_LAST = 16'(DONE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_WAIT,
      S_DONE,
      S_ERROR
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [7:0]  sreg;
   logic [3:0]  vcnt;
   logic [7:0]  clr_cnt;
   logic [15:0] tmo_cnt;
   logic [16:0] pend;
   logic [16:0] rem;
   logic [3:0]  new_cnt;
   logic        all_sent;
   logic        room;
   logic        hs;
   logic        take;
   logic        do_shift;
   logic        restart;
`ifdef CFG_CRC_EN
   logic [7:0]  crc;
   logic        crc_hs;
   logic        crc_match;
`endif

   // Byte-register occupancy and the upstream ready decision.
   always_comb begin
      pend     = {1'b0, bits_sent} + {13'd0, vcnt};
      rem      = TOTAL - pend;
      all_sent = ({1'b0, bits_sent} == TOTAL);
      room     = (state == S_LOAD) && (pend < TOTAL)
                 && (vcnt <= 4'd1);
      new_cnt  = (rem > 17'd8) ? 4'd8 : rem[3:0];
`ifdef CFG_CRC_EN
      cfg_in.s_ready = room || ((state == S_LOAD) && all_sent);
`else
      cfg_in.s_ready = room;
`endif
      hs = cfg_in.s_valid && cfg_in.s_ready;
   end

   // Next state, shift decision and byte-register load strobe.
   always_comb begin
      state_n  = state;
      do_shift = 1'b0;
      take     = 1'b0;
`ifdef CFG_CRC_EN
      crc_hs    = 1'b0;
      crc_match = (cfg_in.s_data == crc);
`endif
      unique case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) state_n = S_CLEAR;
         end
         S_CLEAR: begin
            if (clr_cnt == CLR_LAST) state_n = S_LOAD;
         end
         S_LOAD: begin
            if (chain_done_in) begin
               state_n = S_ERROR;
            end else begin
               do_shift = (vcnt != 4'd0);
               take     = hs && room;
`ifdef CFG_CRC_EN
               if (all_sent && hs) begin
                  crc_hs  = 1'b1;
                  state_n = crc_match ? S_WAIT : S_ERROR;
               end
`else
               if (all_sent) state_n = S_WAIT;
`endif
            end
         end
         S_WAIT: begin
            if (chain_done_in) state_n = S_DONE;
            else if (tmo_cnt == TMO_LAST) state_n = S_ERROR;
         end
         default: state_n = S_IDLE;
      endcase
      restart = (state_n == S_CLEAR) && (state != S_CLEAR);
   end

   // State register and the registered chain-facing outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cfg_clear <= 1'b0;
         prgm_b    <= 1'b1;
         chain_en  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         shift_en  <= 1'b0;
         bit_out   <= 1'b0;
      end else begin
         state     <= state_n;
         cfg_clear <= (state_n == S_CLEAR);
         prgm_b    <= !((state_n == S_LOAD) || (state_n == S_WAIT));
         chain_en  <= (state_n == S_LOAD) || (state_n == S_WAIT);
         busy      <= (state_n == S_CLEAR) || (state_n == S_LOAD)
                      || (state_n == S_WAIT);
         done      <= (state_n == S_DONE);
         error     <= (state_n == S_ERROR);
         shift_en  <= do_shift;
         if (do_shift) bit_out <= sreg[7];
      end
   end

   // Shift register, bit counters and clear/timeout counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg      <= 8'd0;
         vcnt      <= 4'd0;
         clr_cnt   <= 8'd0;
         tmo_cnt   <= 16'd0;
         bits_sent <= 16'd0;
      end else if (restart) begin
         sreg      <= 8'd0;
         vcnt      <= 4'd0;
         clr_cnt   <= 8'd0;
         tmo_cnt   <= 16'd0;
         bits_sent <= 16'd0;
      end else begin
         if (state == S_CLEAR) clr_cnt <= clr_cnt + 8'd1;
         if (state == S_WAIT) tmo_cnt <= tmo_cnt + 16'd1;
         if (take) begin
            sreg <= cfg_in.s_data;
            vcnt <= new_cnt;
         end else if (do_shift) begin
            sreg <= {sreg[6:0], 1'b0};
            vcnt <= vcnt - 4'd1;
         end
         if (do_shift) bits_sent <= bits_sent + 16'd1;
      end
   end

`ifdef CFG_CRC_EN
   // CRC-8 (x^8+x^2+x+1) over every bit presented to the chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc    <= 8'd0;
         crc_ok <= 1'b0;
      end else if (restart) begin
         crc    <= 8'd0;
         crc_ok <= 1'b0;
      end else begin
         if (do_shift)
            crc <= {crc[6:0], 1'b0}
                   ^ ((crc[7] ^ sreg[7]) ? 8'h07 : 8'h00);
         if (crc_hs && crc_match) crc_ok <= 1'b1;
      end
   end
`endif

endmodule
